// File: rtl/axi_llc_desc_router_if.sv
// Default LLC descriptor / count-down types and the router's bus interface.
// The router takes the slave modport; sources and sinks sit on the master side.
package axi_llc_desc_router_pkg;
    typedef struct packed {
        logic [3:0] a_x_id;
        logic       rw;
        logic [7:0] data;
    } llc_desc_t;

    typedef struct packed {
        logic [3:0] id;
        logic       rw;
        logic       valid;
    } llc_cnt_t;
endpackage

interface axi_llc_desc_router_if #(
    parameter int unsigned NumInp    = 2,
    parameter int unsigned FifoDepth = 2,
    parameter type desc_t = axi_llc_desc_router_pkg::llc_desc_t,
    parameter type cnt_t  = axi_llc_desc_router_pkg::llc_cnt_t
);
    localparam int unsigned FillW = $clog2(FifoDepth + 1);

    desc_t [NumInp-1:0] desc_i;
    logic  [NumInp-1:0] valid_i;
    logic  [NumInp-1:0] ready_o;
    desc_t              read_desc_o;
    logic               read_valid_o;
    logic               read_ready_i;
    desc_t              write_desc_o;
    logic               write_valid_o;
    logic               write_ready_i;
    cnt_t  [NumInp-1:0] cnt_down_o;
    logic  [FillW-1:0]  read_fill_o;
    logic  [FillW-1:0]  write_fill_o;
    logic               busy_o;

    modport slave (
        input  desc_i, valid_i, read_ready_i, write_ready_i,
        output ready_o, read_desc_o, read_valid_o, write_desc_o, write_valid_o,
               cnt_down_o, read_fill_o, write_fill_o, busy_o
    );

    modport master (
        output desc_i, valid_i, read_ready_i, write_ready_i,
        input  ready_o, read_desc_o, read_valid_o, write_desc_o, write_valid_o,
               cnt_down_o, read_fill_o, write_fill_o, busy_o
    );
endinterface

// File: rtl/axi_llc_desc_router.sv
// LLC descriptor router: per-output round-robin arbitration by rw into a
// registered read FIFO and write FIFO, plus per-source miss count-down events.
module axi_llc_desc_router_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned FillW = $clog2(Depth + 1),
    parameter type         T     = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  T                 data_i,
    output logic             full_o,
    output T                 data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [FillW-1:0] fill_o
);
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                 mem [Depth];
    logic [AddrW-1:0] wr_ptr, rd_ptr;
    logic [FillW-1:0] fill_q;
    logic             push, pop;

    assign full_o  = (fill_q == FillW'(Depth));
    assign valid_o = (fill_q != '0);
    assign data_o  = mem[rd_ptr];
    assign fill_o  = fill_q;
    // A full FIFO refuses a push even if it pops this cycle (no pass-through).
    assign push    = push_i & ~full_o;
    assign pop     = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AddrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AddrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            fill_q <= fill_q + FillW'(push) - FillW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end
endmodule

module axi_llc_desc_router #(
    parameter int unsigned       NumInp    = 2,
    parameter int unsigned       FifoDepth = 2,
    parameter logic [NumInp-1:0] MissMask  = 'b01,
    parameter type desc_t = axi_llc_desc_router_pkg::llc_desc_t,
    parameter type cnt_t  = axi_llc_desc_router_pkg::llc_cnt_t
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    axi_llc_desc_router_if.slave bus
);
    localparam int unsigned PtrW  = (NumInp > 1) ? $clog2(NumInp) : 1;
    localparam int unsigned FillW = $clog2(FifoDepth + 1);

    // Channel 0 is the read output, channel 1 the write output.
    logic [1:0][NumInp-1:0] acc;
    desc_t [1:0]            out_desc;
    logic [1:0]             out_valid, out_ready;
    logic [1:0][FillW-1:0]  fill;
    logic [NumInp-1:0]      rdy;
    cnt_t [NumInp-1:0]      cnt_d;

    assign out_ready = {bus.write_ready_i, bus.read_ready_i};

    for (genvar ch = 0; ch < 2; ch++) begin : g_out
        localparam logic IsWrite = (ch == 1);

        logic [NumInp-1:0] req, gnt;
        logic [PtrW-1:0]   rr_ptr, gnt_idx;
        logic              full, push;

        always_comb begin
            req = '0;
            for (int unsigned i = 0; i < NumInp; i++)
                req[i] = bus.valid_i[i] & (bus.desc_i[i].rw == IsWrite);
        end

        // First requester at or after the pointer, wrapping around.
        always_comb begin
            int unsigned idx;
            idx     = 0;
            gnt     = '0;
            gnt_idx = '0;
            for (int unsigned k = 0; k < NumInp; k++) begin
                idx = (32'(rr_ptr) + k) % NumInp;
                if (gnt == '0 && req[idx[PtrW-1:0]]) begin
                    gnt[idx[PtrW-1:0]] = 1'b1;
                    gnt_idx            = idx[PtrW-1:0];
                end
            end
        end

        assign push    = (|gnt) & ~full & rst_ni;
        assign acc[ch] = gnt & {NumInp{~full & rst_ni}};

        // The pointer only moves past a source whose descriptor was taken.
        always_ff @(posedge clk_i) begin
            if (!rst_ni)   rr_ptr <= '0;
            else if (push) rr_ptr <= (gnt_idx == PtrW'(NumInp - 1)) ? '0 : gnt_idx + 1'b1;
        end

        axi_llc_desc_router_fifo #(
            .Depth (FifoDepth),
            .FillW (FillW),
            .T     (desc_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push),
            .data_i  (bus.desc_i[gnt_idx]),
            .full_o  (full),
            .data_o  (out_desc[ch]),
            .valid_o (out_valid[ch]),
            .ready_i (out_ready[ch]),
            .fill_o  (fill[ch])
        );
    end

    always_comb begin
        rdy   = '0;
        cnt_d = '0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            rdy[i] = bus.desc_i[i].rw ? acc[1][i] : acc[0][i];
            if (MissMask[i]) begin
                cnt_d[i].id    = bus.desc_i[i].a_x_id;
                cnt_d[i].rw    = bus.desc_i[i].rw;
                cnt_d[i].valid = bus.valid_i[i] & rdy[i];
            end
        end
    end

    assign bus.ready_o       = rdy;
    assign bus.cnt_down_o    = cnt_d;
    assign bus.read_desc_o   = out_desc[0];
    assign bus.read_valid_o  = out_valid[0];
    assign bus.read_fill_o   = fill[0];
    assign bus.write_desc_o  = out_desc[1];
    assign bus.write_valid_o = out_valid[1];
    assign bus.write_fill_o  = fill[1];
    assign bus.busy_o        = (fill[0] != '0) | (fill[1] != '0);
endmodule

// File: tb/tb_axi_llc_desc_router.sv
// Bench for axi_llc_desc_router: directed scenarios on a depth-2 instance,
// a queue-model random run, and an order check on a depth-3 instance.
module tb_axi_llc_desc_router;
    import axi_llc_desc_router_pkg::*;

    localparam logic [1:0] MASK = 2'b10;

    logic clk, rst_n;
    int   n_chk, n_fail;

    axi_llc_desc_router_if #(.NumInp(2), .FifoDepth(2)) ifa ();
    axi_llc_desc_router_if #(.NumInp(2), .FifoDepth(3)) ifb ();

    axi_llc_desc_router #(.NumInp(2), .FifoDepth(2), .MissMask(MASK)) dut_a (
        .clk_i (clk), .rst_ni (rst_n), .bus (ifa)
    );
    axi_llc_desc_router #(.NumInp(2), .FifoDepth(3), .MissMask(MASK)) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic llc_desc_t mk(input logic rw, input logic [3:0] id, input logic [7:0] data);
        llc_desc_t d;
        d.rw     = rw;
        d.a_x_id = id;
        d.data   = data;
        return d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.desc_i[0] = mk(1'b0, 4'd1, 8'h01);
        ifa.desc_i[1] = mk(1'b1, 4'd2, 8'h02);
        ifa.valid_i = 2'b11;
        ifa.read_ready_i = 1'b1;
        ifa.write_ready_i = 1'b1;
        #1;
        n_chk++; if (ifa.ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", ifa.ready_o); end
        n_chk++; if (ifa.cnt_down_o[1].valid !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_valid got=%b exp=0", ifa.cnt_down_o[1].valid); end
        tick();
        rst_n = 1'b1;
        ifa.valid_i = 2'b00;
        #1;
        n_chk++; if (ifa.read_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", ifa.read_valid_o); end
        n_chk++; if (ifa.write_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid got=%b exp=0", ifa.write_valid_o); end
        n_chk++; if (ifa.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", ifa.busy_o); end
        n_chk++; if (ifa.read_fill_o !== 2'd0 || ifa.write_fill_o !== 2'd0) begin n_fail++; $display("FAIL reset_fill got=%0d/%0d exp=0/0", ifa.read_fill_o, ifa.write_fill_o); end
        tick();
    endtask

    task automatic test_single();
        llc_cnt_t ec;
        ec.id = 4'd5; ec.rw = 1'b0; ec.valid = 1'b1;
        ifa.read_ready_i = 1'b1;
        ifa.write_ready_i = 1'b1;
        ifa.desc_i[1] = mk(1'b0, 4'd5, 8'h51);
        ifa.valid_i = 2'b10;
        #1;
        n_chk++; if (ifa.ready_o !== 2'b10) begin n_fail++; $display("FAIL single_ready got=%b exp=10", ifa.ready_o); end
        n_chk++; if (ifa.cnt_down_o[1] !== ec) begin n_fail++; $display("FAIL single_cnt got=%h exp=%h", ifa.cnt_down_o[1], ec); end
        tick();
        ifa.valid_i = 2'b00;
        #1;
        n_chk++; if (ifa.read_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_rvalid got=%b exp=1", ifa.read_valid_o); end
        n_chk++; if (ifa.read_fill_o !== 2'd1) begin n_fail++; $display("FAIL single_fill got=%0d exp=1", ifa.read_fill_o); end
        n_chk++; if (ifa.read_desc_o.data !== 8'h51) begin n_fail++; $display("FAIL single_desc got=%h exp=51", ifa.read_desc_o.data); end
        tick();
        #1;
        n_chk++; if (ifa.read_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", ifa.read_valid_o); end
        tick();
    endtask

    task automatic test_contention();
        logic [7:0] prev;
        int g;
        prev = '0;
        ifa.write_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ifa.desc_i[0] = mk(1'b1, 4'd0, 8'(8'h00 + c));
            ifa.desc_i[1] = mk(1'b1, 4'd1, 8'(8'h10 + c));
            ifa.valid_i = 2'b11;
            #1;
            g = c % 2;
            n_chk++; if (ifa.ready_o !== 2'(1 << g)) begin n_fail++; $display("FAIL cont_grant c=%0d got=%b exp_src=%0d", c, ifa.ready_o, g); end
            n_chk++; if (ifa.cnt_down_o[0].valid !== 1'b0) begin n_fail++; $display("FAIL cont_cnt0 c=%0d got=1 exp=0", c); end
            n_chk++; if (ifa.cnt_down_o[1].valid !== (g == 1)) begin n_fail++; $display("FAIL cont_cnt1 c=%0d got=%b", c, ifa.cnt_down_o[1].valid); end
            if (c > 0) begin
                n_chk++; if (ifa.write_desc_o.data !== prev || ifa.write_valid_o !== 1'b1) begin n_fail++; $display("FAIL cont_wdesc c=%0d got=%h exp=%h", c, ifa.write_desc_o.data, prev); end
            end
            prev = (g == 1) ? 8'(8'h10 + c) : 8'(c);
            tick();
        end
        ifa.valid_i = 2'b00;
        tick();
        tick();
        n_chk++; if (ifa.write_valid_o !== 1'b0) begin n_fail++; $display("FAIL cont_drain got=%b exp=0", ifa.write_valid_o); end
    endtask

    task automatic test_concurrency();
        ifa.read_ready_i = 1'b1;
        ifa.write_ready_i = 1'b1;
        ifa.desc_i[0] = mk(1'b1, 4'd3, 8'h33);
        ifa.desc_i[1] = mk(1'b0, 4'd4, 8'h44);
        ifa.valid_i = 2'b11;
        #1;
        n_chk++; if (ifa.ready_o !== 2'b11) begin n_fail++; $display("FAIL conc_ready got=%b exp=11", ifa.ready_o); end
        tick();
        ifa.valid_i = 2'b00;
        #1;
        n_chk++; if (ifa.read_valid_o !== 1'b1 || ifa.read_desc_o.data !== 8'h44) begin n_fail++; $display("FAIL conc_read got=%b/%h exp=1/44", ifa.read_valid_o, ifa.read_desc_o.data); end
        n_chk++; if (ifa.write_valid_o !== 1'b1 || ifa.write_desc_o.data !== 8'h33) begin n_fail++; $display("FAIL conc_write got=%b/%h exp=1/33", ifa.write_valid_o, ifa.write_desc_o.data); end
        tick();
        tick();
    endtask

    task automatic test_full();
        ifa.read_ready_i = 1'b0;
        ifa.valid_i = 2'b01;
        ifa.desc_i[0] = mk(1'b0, 4'd0, 8'd1);
        #1;
        n_chk++; if (ifa.ready_o !== 2'b01) begin n_fail++; $display("FAIL full_acc1 got=%b exp=01", ifa.ready_o); end
        tick();
        ifa.desc_i[0] = mk(1'b0, 4'd0, 8'd2);
        #1;
        n_chk++; if (ifa.ready_o !== 2'b01) begin n_fail++; $display("FAIL full_acc2 got=%b exp=01", ifa.ready_o); end
        tick();
        ifa.desc_i[0] = mk(1'b0, 4'd0, 8'd3);
        #1;
        n_chk++; if (ifa.read_fill_o !== 2'd2) begin n_fail++; $display("FAIL full_fill got=%0d exp=2", ifa.read_fill_o); end
        n_chk++; if (ifa.ready_o !== 2'b00) begin n_fail++; $display("FAIL full_block got=%b exp=00", ifa.ready_o); end
        tick();
        ifa.read_ready_i = 1'b1;
        #1;
        n_chk++; if (ifa.ready_o !== 2'b00) begin n_fail++; $display("FAIL full_nopass got=%b exp=00", ifa.ready_o); end
        n_chk++; if (ifa.read_desc_o.data !== 8'd1) begin n_fail++; $display("FAIL full_out1 got=%0d exp=1", ifa.read_desc_o.data); end
        tick();
        #1;
        n_chk++; if (ifa.read_fill_o !== 2'd1 || ifa.ready_o !== 2'b01) begin n_fail++; $display("FAIL full_acc3 got=%0d/%b exp=1/01", ifa.read_fill_o, ifa.ready_o); end
        n_chk++; if (ifa.read_desc_o.data !== 8'd2) begin n_fail++; $display("FAIL full_out2 got=%0d exp=2", ifa.read_desc_o.data); end
        tick();
        ifa.valid_i = 2'b00;
        #1;
        n_chk++; if (ifa.read_desc_o.data !== 8'd3 || ifa.read_fill_o !== 2'd1) begin n_fail++; $display("FAIL full_out3 got=%0d/%0d exp=3/1", ifa.read_desc_o.data, ifa.read_fill_o); end
        tick();
        #1;
        n_chk++; if (ifa.read_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_drain got=%b exp=0", ifa.read_valid_o); end
    endtask

    task automatic test_reset_mid();
        ifa.read_ready_i = 1'b0;
        ifa.write_ready_i = 1'b0;
        ifa.desc_i[0] = mk(1'b1, 4'd1, 8'hA0);
        ifa.desc_i[1] = mk(1'b0, 4'd2, 8'hB0);
        ifa.valid_i = 2'b11;
        tick();
        tick();
        #1;
        n_chk++; if (ifa.read_fill_o !== 2'd2 || ifa.write_fill_o !== 2'd2) begin n_fail++; $display("FAIL rmid_fill got=%0d/%0d exp=2/2", ifa.read_fill_o, ifa.write_fill_o); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (ifa.ready_o !== 2'b00) begin n_fail++; $display("FAIL rmid_ready got=%b exp=00", ifa.ready_o); end
        n_chk++; if (ifa.cnt_down_o[1].valid !== 1'b0) begin n_fail++; $display("FAIL rmid_cnt got=1 exp=0"); end
        tick();
        rst_n = 1'b1;
        ifa.valid_i = 2'b00;
        #1;
        n_chk++; if (ifa.busy_o !== 1'b0 || ifa.read_valid_o !== 1'b0 || ifa.write_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_empty got=%b%b%b exp=000", ifa.busy_o, ifa.read_valid_o, ifa.write_valid_o); end
        ifa.write_ready_i = 1'b1;
        ifa.desc_i[1] = mk(1'b1, 4'd2, 8'hB1);
        ifa.valid_i = 2'b11;
        #1;
        n_chk++; if (ifa.ready_o !== 2'b01) begin n_fail++; $display("FAIL rmid_rr got=%b exp=01", ifa.ready_o); end
        tick();
        ifa.valid_i = 2'b00;
        tick();
        tick();
    endtask

    // Reference model: one queue per output, round-robin pointers as ints.
    llc_desc_t mq_r[$], mq_w[$];
    int        m_ptr [2];

    function automatic int qsize(input int ch);
        return (ch == 0) ? mq_r.size() : mq_w.size();
    endfunction

    task automatic test_random();
        logic [1:0]      exp_rdy;
        llc_cnt_t [1:0]  exp_cnt;
        int              win [2];
        bit              full [2];
        int              i;
        for (int c = 0; c < 400; c++) begin
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            ifa.valid_i = 2'($urandom_range(0, 3));
            for (int s = 0; s < 2; s++)
                ifa.desc_i[s] = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            ifa.read_ready_i = ($urandom_range(0, 3) != 0);
            ifa.write_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = '0;
            for (int ch = 0; ch < 2; ch++) begin
                win[ch] = -1;
                full[ch] = (qsize(ch) == 2);
                for (int k = 0; k < 2; k++) begin
                    i = (m_ptr[ch] + k) % 2;
                    if (win[ch] < 0 && ifa.valid_i[i] && int'(ifa.desc_i[i].rw) == ch) win[ch] = i;
                end
                if (rst_n && win[ch] >= 0 && !full[ch]) exp_rdy[win[ch]] = 1'b1;
            end
            for (int s = 0; s < 2; s++) begin
                exp_cnt[s] = '0;
                if (MASK[s]) begin
                    exp_cnt[s].id = ifa.desc_i[s].a_x_id;
                    exp_cnt[s].rw = ifa.desc_i[s].rw;
                    exp_cnt[s].valid = exp_rdy[s];
                end
            end
            n_chk++; if (ifa.ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ifa.ready_o, exp_rdy); end
            n_chk++; if (ifa.cnt_down_o !== exp_cnt) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%h exp=%h", c, ifa.cnt_down_o, exp_cnt); end
            n_chk++; if (ifa.read_valid_o !== (mq_r.size() > 0) || int'(ifa.read_fill_o) != mq_r.size()) begin n_fail++; $display("FAIL rnd_read c=%0d got=%b/%0d exp_fill=%0d", c, ifa.read_valid_o, ifa.read_fill_o, mq_r.size()); end
            n_chk++; if (ifa.write_valid_o !== (mq_w.size() > 0) || int'(ifa.write_fill_o) != mq_w.size()) begin n_fail++; $display("FAIL rnd_write c=%0d got=%b/%0d exp_fill=%0d", c, ifa.write_valid_o, ifa.write_fill_o, mq_w.size()); end
            n_chk++; if (ifa.busy_o !== (mq_r.size() + mq_w.size() > 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b", c, ifa.busy_o); end
            if (mq_r.size() > 0) begin
                n_chk++; if (ifa.read_desc_o !== mq_r[0]) begin n_fail++; $display("FAIL rnd_rdesc c=%0d got=%h exp=%h", c, ifa.read_desc_o, mq_r[0]); end
            end
            if (mq_w.size() > 0) begin
                n_chk++; if (ifa.write_desc_o !== mq_w[0]) begin n_fail++; $display("FAIL rnd_wdesc c=%0d got=%h exp=%h", c, ifa.write_desc_o, mq_w[0]); end
            end
            if (!rst_n) begin
                mq_r.delete();
                mq_w.delete();
                m_ptr[0] = 0;
                m_ptr[1] = 0;
            end else begin
                if (mq_r.size() > 0 && ifa.read_ready_i) void'(mq_r.pop_front());
                if (mq_w.size() > 0 && ifa.write_ready_i) void'(mq_w.pop_front());
                for (int ch = 0; ch < 2; ch++) begin
                    if (win[ch] >= 0 && !full[ch]) begin
                        if (ch == 0) mq_r.push_back(ifa.desc_i[win[ch]]);
                        else         mq_w.push_back(ifa.desc_i[win[ch]]);
                        m_ptr[ch] = (win[ch] + 1) % 2;
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1;
        ifa.valid_i = 2'b00;
        tick();
    endtask

    task automatic test_nonpow2();
        int sent, got;
        sent = 0;
        got = 0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            ifb.valid_i = (sent < 10 && $urandom_range(0, 3) != 0) ? 2'b01 : 2'b00;
            ifb.desc_i[0] = mk(1'b0, 4'd0, 8'(sent));
            ifb.read_ready_i = ($urandom_range(0, 2) == 0);
            #1;
            n_chk++; if (ifb.read_fill_o > 2'd3) begin n_fail++; $display("FAIL np2_fill c=%0d got=%0d max=3", c, ifb.read_fill_o); end
            if (ifb.read_fill_o == 2'd3 && ifb.valid_i[0]) begin
                n_chk++; if (ifb.ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL np2_full_ready c=%0d got=1 exp=0", c); end
            end
            if (ifb.read_valid_o && ifb.read_ready_i) begin
                n_chk++; if (ifb.read_desc_o.data !== 8'(got)) begin n_fail++; $display("FAIL np2_order got=%0d exp=%0d", ifb.read_desc_o.data, got); end
                got++;
            end
            if (ifb.ready_o[0]) sent++;
            tick();
        end
        ifb.valid_i = 2'b00;
        n_chk++; if (got != 10) begin n_fail++; $display("FAIL np2_count got=%0d exp=10", got); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        m_ptr[0] = 0;
        m_ptr[1] = 0;
        ifa.valid_i = '0; ifa.desc_i = '0; ifa.read_ready_i = 1'b0; ifa.write_ready_i = 1'b0;
        ifb.valid_i = '0; ifb.desc_i = '0; ifb.read_ready_i = 1'b0; ifb.write_ready_i = 1'b0;
        tick();
        tick();
        test_reset();
        test_single();
        test_contention();
        test_concurrency();
        test_full();
        test_reset_mid();
        test_random();
        test_nonpow2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
